// File: rtl/vending_machine_multi.sv
// Multi-item vending controller.
// Accepts unit coins, tracks credit, dispenses one of N_ITEM products at
// per-item prices and returns change one coin unit at a time. All panel
// inputs are edge-detected here. Outputs depend only on registered state,
// so every response appears one cycle after the input edge that caused it.
module vending_machine_multi #(
    parameter int                         N_ITEM       = 4,
    parameter int                         CREDIT_W     = 4,
    parameter int                         MAX_CREDIT   = 9,
    parameter logic [N_ITEM*CREDIT_W-1:0] PRICE        = {4'd3, 4'd2, 4'd2, 4'd1},
    parameter int                         DISPENSE_CYC = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_coin,
    input  logic [N_ITEM-1:0]   i_sel,
    input  logic                i_cancel,
    output logic [N_ITEM-1:0]   o_led,
    output logic [N_ITEM-1:0]   o_item,
    output logic                o_change,
    output logic                o_reject,
    output logic [CREDIT_W-1:0] o_credit,
    output logic [7:0]          o_seg,
    output logic                o_busy
);

    localparam int CNT_W = (DISPENSE_CYC > 1) ? $clog2(DISPENSE_CYC) : 1;
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(DISPENSE_CYC - 1);
    localparam logic [CREDIT_W-1:0] MAX_C    = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] ONE_C    = CREDIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    state_t              state_reg;
    logic [CREDIT_W-1:0] credit_reg;
    logic [N_ITEM-1:0]   item_reg;
    logic                change_reg;
    logic                reject_reg;
    logic [CNT_W-1:0]    cnt_reg;

    // Previous-value registers for edge detection
    logic                coin_prev_reg;
    logic [N_ITEM-1:0]   sel_prev_reg;
    logic                cancel_prev_reg;

    logic                coin_edge;
    logic [N_ITEM-1:0]   sel_edge;
    logic                cancel_edge;

    logic [CREDIT_W-1:0] price_arr [N_ITEM];

    logic                sel_found;
    logic [N_ITEM-1:0]   sel_onehot;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_ok;

    logic [31:0]         credit_ext;
    logic [7:0]          seg_next;

    assign coin_edge   = i_coin & ~coin_prev_reg;
    assign sel_edge    = i_sel & ~sel_prev_reg;
    assign cancel_edge = i_cancel & ~cancel_prev_reg;

    // Per-item price slices and affordability LEDs
    generate
        for (genvar gi = 0; gi < N_ITEM; gi++) begin : g_item
            assign price_arr[gi] = PRICE[gi*CREDIT_W +: CREDIT_W];
            assign o_led[gi]     = (state_reg == ST_CREDIT)
                                 && (price_arr[gi] != '0)
                                 && (credit_reg >= price_arr[gi]);
        end
    endgenerate

    // Pick the lowest-index item button that saw a rising edge
    always_comb begin
        sel_found  = 1'b0;
        sel_onehot = '0;
        sel_price  = '0;
        for (int k = 0; k < N_ITEM; k++) begin
            if (!sel_found && sel_edge[k]) begin
                sel_found     = 1'b1;
                sel_onehot[k] = 1'b1;
                sel_price     = price_arr[k];
            end
        end
    end

    assign sel_ok = sel_found && (sel_price != '0) && (credit_reg >= sel_price);

    // Main controller: edge history, state, credit and registered strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            credit_reg      <= '0;
            item_reg        <= '0;
            change_reg      <= 1'b0;
            reject_reg      <= 1'b0;
            cnt_reg         <= '0;
            // Load ones so inputs held high across reset release do not edge
            coin_prev_reg   <= 1'b1;
            sel_prev_reg    <= '1;
            cancel_prev_reg <= 1'b1;
        end else begin
            coin_prev_reg   <= i_coin;
            sel_prev_reg    <= i_sel;
            cancel_prev_reg <= i_cancel;
            reject_reg      <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (coin_edge) begin
                        credit_reg <= ONE_C;
                        state_reg  <= ST_CREDIT;
                    end
                end

                ST_CREDIT: begin
                    if (cancel_edge) begin
                        // Credit is always nonzero here, so the first pulse goes out next cycle
                        state_reg  <= ST_CHANGE;
                        change_reg <= 1'b1;
                        reject_reg <= coin_edge;
                    end else if (sel_found) begin
                        reject_reg <= coin_edge;
                        if (sel_ok) begin
                            credit_reg <= credit_reg - sel_price;
                            item_reg   <= sel_onehot;
                            cnt_reg    <= CNT_LOAD;
                            state_reg  <= ST_VEND;
                        end
                    end else if (coin_edge) begin
                        if (credit_reg < MAX_C) begin
                            credit_reg <= credit_reg + ONE_C;
                        end else begin
                            reject_reg <= 1'b1;
                        end
                    end
                end

                ST_VEND: begin
                    reject_reg <= coin_edge;
                    if (cnt_reg == '0) begin
                        item_reg <= '0;
                        if (credit_reg != '0) begin
                            state_reg  <= ST_CHANGE;
                            change_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                ST_CHANGE: begin
                    reject_reg <= coin_edge;
                    // Credit drops at the end of each high cycle; leave after the trailing low cycle
                    if (change_reg) begin
                        change_reg <= 1'b0;
                        credit_reg <= credit_reg - ONE_C;
                    end else if (credit_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        change_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign credit_ext = 32'(credit_reg);

    // Seven-segment decode of the credit, dash when out of digit range
    always_comb begin
        seg_next = 8'h40;
        case (credit_ext)
            32'd0:   seg_next = 8'h3F;
            32'd1:   seg_next = 8'h06;
            32'd2:   seg_next = 8'h5B;
            32'd3:   seg_next = 8'h4F;
            32'd4:   seg_next = 8'h66;
            32'd5:   seg_next = 8'h6D;
            32'd6:   seg_next = 8'h7D;
            32'd7:   seg_next = 8'h07;
            32'd8:   seg_next = 8'h7F;
            32'd9:   seg_next = 8'h6F;
            default: seg_next = 8'h40;
        endcase
    end

    assign o_item   = item_reg;
    assign o_change = change_reg;
    assign o_reject = reject_reg;
    assign o_credit = credit_reg;
    assign o_seg    = seg_next;
    assign o_busy   = (state_reg == ST_VEND) || (state_reg == ST_CHANGE);

endmodule
